// File: rtl/mem_agu_stage.sv
// mem_agu_stage
// -------------
// Address-generation and request-buffering stage that sits between the
// memory issue queue and the load/store unit. Each accepted op has its
// effective address, byte mask, lane-aligned store data and misalignment
// flag computed on entry. The results are held in a 2-entry in-order buffer
// and handed to the load/store unit over a valid/ready request port.
// Buffered and incoming ops younger than a flushing ROB id are squashed.
//
// Ports:
//   clock, reset           single clock; synchronous active-high reset
//   isq_*                  op offered by the issue queue (valid/ready)
//   flush_valid/robid      squash every op strictly younger than flush_robid
//   req_*                  request to the load/store unit (valid/ready),
//                          always driven from buffer slot 0

module mem_agu_stage #(
  parameter int XLEN         = 64,
  parameter int ISQ_ID_W     = 4,
  parameter int PRD_W        = 6,
  parameter int ROB_SIZE_LOG = 6,
  parameter int ROBID_W      = ROB_SIZE_LOG + 1
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                isq_valid,
  output logic                isq_ready,
  input  logic [ISQ_ID_W-1:0] isq_id,
  input  logic [ROBID_W-1:0]  isq_robid,
  input  logic                isq_is_store,
  input  logic [1:0]          isq_size,
  input  logic                isq_unsigned,
  input  logic [XLEN-1:0]     isq_base,
  input  logic [XLEN-1:0]     isq_imm,
  input  logic [XLEN-1:0]     isq_sdata,
  input  logic [PRD_W-1:0]    isq_prd,

  input  logic                flush_valid,
  input  logic [ROBID_W-1:0]  flush_robid,

  output logic                req_valid,
  input  logic                req_ready,
  output logic [XLEN-1:0]     req_addr,
  output logic [7:0]          req_wmask,
  output logic [XLEN-1:0]     req_wdata,
  output logic                req_is_store,
  output logic [1:0]          req_size,
  output logic                req_unsigned,
  output logic [PRD_W-1:0]    req_prd,
  output logic [ROBID_W-1:0]  req_robid,
  output logic [ISQ_ID_W-1:0] req_isq_id,
  output logic                req_misaligned
);

  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic [7:0]          wmask;
    logic [XLEN-1:0]     wdata;
    logic                is_store;
    logic [1:0]          size;
    logic                is_unsigned;
    logic [PRD_W-1:0]    prd;
    logic [ROBID_W-1:0]  robid;
    logic [ISQ_ID_W-1:0] isq_id;
    logic                misaligned;
  } entry_t;

  // The MSB of a ROB id is a wrap bit: when the wrap bits differ the index
  // comparison flips, because one id has lapped the ROB. Equal ids are not
  // younger.
  function automatic logic younger(input logic [ROBID_W-1:0] a,
                                   input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1])
      return a[ROBID_W-2:0] > b[ROBID_W-2:0];
    else
      return a[ROBID_W-2:0] < b[ROBID_W-2:0];
  endfunction

  entry_t     slot0, slot1;
  entry_t     slot0_next, slot1_next;
  entry_t     new_entry;
  logic [1:0] count, count_next;

  logic [XLEN-1:0] eff_addr;
  logic [2:0]      off;
  logic [7:0]      size_mask;
  logic            misaligned;

  logic head_kill, s1_kill, in_kill;
  logic accept, deq;
  logic keep0, keep1, keep_in;

  // Address generation on the incoming op. The base mask covers 1/2/4/8
  // bytes and is shifted to the byte offset. Bits shifted past lane 7 are
  // dropped, so a straddling access only marks the lanes inside this dword.
  always_comb begin
    eff_addr   = isq_base + isq_imm;
    off        = eff_addr[2:0];
    size_mask  = 8'h00;
    misaligned = 1'b0;
    case (isq_size)
      2'd0: begin size_mask = 8'h01; misaligned = 1'b0;           end
      2'd1: begin size_mask = 8'h03; misaligned = eff_addr[0];    end
      2'd2: begin size_mask = 8'h0F; misaligned = |eff_addr[1:0]; end
      2'd3: begin size_mask = 8'hFF; misaligned = |eff_addr[2:0]; end
      default: begin size_mask = 8'h00; misaligned = 1'b0;        end
    endcase

    new_entry             = '0;
    new_entry.addr        = eff_addr;
    new_entry.wmask       = size_mask << off;
    new_entry.wdata       = isq_sdata << {off, 3'b000};
    new_entry.is_store    = isq_is_store;
    new_entry.size        = isq_size;
    new_entry.is_unsigned = isq_unsigned;
    new_entry.prd         = isq_prd;
    new_entry.robid       = isq_robid;
    new_entry.isq_id      = isq_id;
    new_entry.misaligned  = misaligned;
  end

  // Ready depends only on the registered occupancy, so there is no
  // combinational path from req_ready back to the issue queue.
  always_comb begin
    isq_ready = (count != 2'd2);
    head_kill = flush_valid && younger(slot0.robid, flush_robid);
    s1_kill   = flush_valid && younger(slot1.robid, flush_robid);
    in_kill   = flush_valid && younger(isq_robid, flush_robid);
    req_valid = (count != 2'd0) && !head_kill;
    accept    = isq_valid && isq_ready;
    deq       = req_valid && req_ready;
    keep0     = (count != 2'd0) && !head_kill && !deq;
    keep1     = (count == 2'd2) && !s1_kill;
    keep_in   = accept && !in_kill;
  end

  // Rebuild the buffer by compacting the survivors in program order: the
  // old head (if not dequeued or killed), the old second entry, then the
  // incoming op. Keeping all three is impossible because a full buffer
  // cannot accept, so the count never exceeds 2.
  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    count_next = 2'd0;
    if (keep0) begin
      slot0_next = slot0;
      count_next = 2'd1;
    end
    if (keep1) begin
      if (count_next == 2'd0)
        slot0_next = slot1;
      else
        slot1_next = slot1;
      count_next = count_next + 2'd1;
    end
    if (keep_in) begin
      if (count_next == 2'd0)
        slot0_next = new_entry;
      else
        slot1_next = new_entry;
      count_next = count_next + 2'd1;
    end
  end

  // Buffer state. Reset clears the occupancy and the data, so the request
  // fields read as zero until the first op arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      count <= count_next;
      slot0 <= slot0_next;
      slot1 <= slot1_next;
    end
  end

  always_comb begin
    req_addr       = slot0.addr;
    req_wmask      = slot0.wmask;
    req_wdata      = slot0.wdata;
    req_is_store   = slot0.is_store;
    req_size       = slot0.size;
    req_unsigned   = slot0.is_unsigned;
    req_prd        = slot0.prd;
    req_robid      = slot0.robid;
    req_isq_id     = slot0.isq_id;
    req_misaligned = slot0.misaligned;
  end

endmodule

// File: doc/mem_agu_stage.md
# mem_agu_stage

Address-generation and request-buffering stage directly downstream of the memory issue queue. Accepts one issued load/store per cycle from the queue's dequeue port and computes the effective address, byte mask and aligned store data. Holds results in a 2-entry in-order buffer and presents them to the load/store unit over a valid/ready request port. Squashes buffered and incoming ops younger than a flushing ROB id.

## Interface
- XLEN, 64: data/address width; fixed at 64 (8-byte mask).
- ISQ_ID_W, 4: width of the issue-queue entry id carried alongside each op ($clog2(8)+1).
- PRD_W, 6: physical destination register tag width.
- ROBID_W, `ROB_SIZE_LOG+1: ROB id width; MSB is the wrap bit.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- isq_valid  in  1  op offered by the memory issue queue.
- isq_ready  out  1  stage can take an op this cycle.
- isq_id  in  ISQ_ID_W  issue-queue entry id; passed through.
- isq_robid  in  ROBID_W  ROB id of the op.
- isq_is_store  in  1  1 = store, 0 = load.
- isq_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- isq_unsigned  in  1  load zero-extend flag; passed through.
- isq_base  in  XLEN  rs1 value.
- isq_imm  in  XLEN  immediate, already sign-extended.
- isq_sdata  in  XLEN  rs2 store data (don't-care for loads).
- isq_prd  in  PRD_W  destination tag; passed through.
- flush_valid  in  1  squash request.
- flush_robid  in  ROBID_W  ops strictly younger than this id are squashed.
- req_valid  out  1  request to the load/store unit.
- req_ready  in  1  load/store unit accepts the request.
- req_addr  out  XLEN  effective address.
- req_wmask  out  8  byte-lane mask.
- req_wdata  out  XLEN  store data shifted to its byte lane.
- req_is_store, req_size, req_unsigned, req_prd, req_robid, req_isq_id  out  as input  passed-through fields.
- req_misaligned  out  1  address not naturally aligned to size.

## Operation
- Accept when isq_valid && isq_ready. Compute combinationally on input and write into the buffer tail:
  - addr = isq_base + isq_imm, mod 2^64, carry dropped.
  - off = addr[2:0].
  - wmask = ((1 << (1 << size)) - 1) << off, truncated to 8 bits.
  - wdata = isq_sdata << (8*off), truncated to XLEN.
  - misaligned = (addr & ((1 << size) - 1)) != 0.
- Misaligned ops are still buffered and emitted with req_misaligned=1; the load/store unit raises the exception.
- Buffer: 2 entries, in order. Slot 0 is the head; count is 0..2. isq_ready = (count < 2). isq_ready is derived only from registered count, with no combinational path from req_ready.
- Output: req_* come from slot 0. req_valid = slot0_valid && !(flush_valid && younger(slot0.robid, flush_robid)).
- Dequeue on req_valid && req_ready; slot 1 shifts into slot 0 on the same edge.
- Enqueue and dequeue in the same cycle at count 1: the new op lands in slot 0 and count stays 1.
- younger(a,b) = (a.msb == b.msb) ? (a.idx > b.idx) : (a.idx < b.idx). Equal ids are not younger.
- Flush: ops arrive in program order, so a flush always kills a suffix. On an edge with flush_valid:
  - Every buffered entry younger than flush_robid is invalidated and count is reduced.
  - An incoming op that is younger is dropped. Its isq handshake still completes, because the queue has already squashed it.
  - Older entries and an older incoming op are retained normally.
  - A dequeue of a masked head cannot occur, since req_valid is 0 for it.

## Timing
- Reset: count=0, all slot valids 0. req_valid=0 and isq_ready=1 in the first cycle after reset is released. req_* data fields are 0.
- Reset takes priority over flush, enqueue and dequeue. Reset mid-operation discards all entries.
- Latency: op accepted at edge N; req_valid=1 from cycle N+1. Zero-bubble throughput of 1 op/cycle when req_ready is held high.
- With req_ready=0, accepts two ops, then isq_ready=0 from the next cycle.
- When req_ready falls, req_* hold stable until accepted, unless killed by flush.

## Test plan
- Basic load: base=0x1000, imm=0xFFFFFFFFFFFFFFFC (−4), size=2 -> next cycle req_addr=0x0FFC, wmask=0xF0, misaligned=0.
- Store lane shift: base=0x2003, imm=0, size=0, sdata=0xAB -> wmask=0x08, wdata=0xAB000000, misaligned=0. Repeat with size=1 at 0x2003 -> misaligned=1, wmask=0x18.
- Backpressure: hold req_ready=0 and offer 3 ops -> first two accepted, isq_ready=0 from cycle 3. Release -> ops emerge in order, one per cycle, and the third is accepted the cycle isq_ready returns.
- Flush with wrap: buffer robids {0x3E, 0x01(wrap=1)}, flush_robid=0x3F(wrap=0) -> slot 1 killed, slot 0 kept, count=1. Flush_robid=0x3E -> same result (equal id not killed).
- Flush of head with concurrent enqueue: head robid 5, incoming robid 6, flush_robid 4 -> req_valid=0 that cycle, count=0 after the edge, and the incoming op is dropped.
- Synchronous reset asserted with 2 entries buffered -> req_valid=0 and isq_ready=1 after the edge. Address wrap: base=0xFFFFFFFFFFFFFFFF, imm=1 -> req_addr=0.
